// File: rtl/systolic_array_ctrl_pkg.sv
// Shared definitions for the 3x3 systolic array job sequencer: defaults, state
// encoding and the operand/result packing offsets used by RTL, wrapper and bench.
package systolic_pkg;

  localparam int N              = 3;
  localparam int WIDTH          = 12;
  localparam int WIDTH_SUM      = 8;
  localparam int COMPUTE_CYCLES = 7;
  localparam int ELEM_W         = WIDTH / N;
  localparam int CNT_W          = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Row i of A (or column i of B), 0-based; row/column 1 sits in the MSBs.
  function automatic int row_ofs(input int i);
    return (N - 1 - i) * WIDTH;
  endfunction

  // Element j inside one row/column slice, 0-based; element 1 in the MSBs.
  function automatic int elem_ofs(input int j);
    return (N - 1 - j) * ELEM_W;
  endfunction

  // C(i,j), 0-based, row-major with C_1x1 in the MSBs.
  function automatic int c_ofs(input int i, input int j);
    return (N * N - 1 - (N * i + j)) * WIDTH_SUM;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Host-side job interface: operand handshake in, result handshake out.
interface systolic_array_ctrl_if #(
    parameter int WIDTH     = systolic_pkg::WIDTH,
    parameter int WIDTH_SUM = systolic_pkg::WIDTH_SUM
);
    logic                   in_valid;
    logic                   in_ready;
    logic [3*WIDTH-1:0]     a_mat;
    logic [3*WIDTH-1:0]     b_mat;
    logic                   out_valid;
    logic                   out_ready;
    logic [9*WIDTH_SUM-1:0] c_mat;
    logic                   overflow;
    logic [7:0]             done_cnt;

    modport master (
        output in_valid, a_mat, b_mat, out_ready,
        input  in_ready, out_valid, c_mat, overflow, done_cnt
    );

    modport slave (
        input  in_valid, a_mat, b_mat, out_ready,
        output in_ready, out_valid, c_mat, overflow, done_cnt
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the 3x3 systolic array: holds operands, clears and runs the
// array for a fixed window, then offers the captured products to the consumer.
module systolic_array_ctrl #(
    parameter int WIDTH          = systolic_pkg::WIDTH,
    parameter int WIDTH_SUM      = systolic_pkg::WIDTH_SUM,
    parameter int COMPUTE_CYCLES = systolic_pkg::COMPUTE_CYCLES
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    systolic_array_ctrl_if.slave   s_job,
    output logic                   o_arr_rst,
    output logic                   o_arr_enable,
    output logic [WIDTH-1:0]       o_arr_a_row1,
    output logic [WIDTH-1:0]       o_arr_a_row2,
    output logic [WIDTH-1:0]       o_arr_a_row3,
    output logic [WIDTH-1:0]       o_arr_b_coloum1,
    output logic [WIDTH-1:0]       o_arr_b_coloum2,
    output logic [WIDTH-1:0]       o_arr_b_coloum3,
    input  logic [9*WIDTH_SUM-1:0] i_arr_c,
    input  logic                   i_arr_over
);
    import systolic_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [3*WIDTH-1:0]     r_a_hold;
    logic [3*WIDTH-1:0]     r_b_hold;
    logic [9*WIDTH_SUM-1:0] r_c;
    logic                   r_ovf;
    logic [7:0]             r_done_cnt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_arr_rst;
    logic                   r_arr_en;

    // Outputs are registered alongside the state so each one already
    // reflects the state being entered on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a_hold    <= '0;
            r_b_hold    <= '0;
            r_c         <= '0;
            r_ovf       <= 1'b0;
            r_done_cnt  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_arr_rst   <= 1'b0;
            r_arr_en    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_job.in_valid && r_in_ready) begin
                        r_a_hold   <= s_job.a_mat;
                        r_b_hold   <= s_job.b_mat;
                        r_in_ready <= 1'b0;
                        r_arr_rst  <= 1'b0;
                        r_state    <= CLEAR;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_arr_rst  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_cnt     <= '0;
                    r_arr_rst <= 1'b1;
                    r_arr_en  <= 1'b1;
                    r_state   <= RUN;
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_arr_en <= 1'b0;
                        r_state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_c         <= i_arr_c;
                    r_ovf       <= i_arr_over;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (s_job.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_done_cnt  <= r_done_cnt + 1'b1;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_job.in_ready  = r_in_ready;
    assign s_job.out_valid = r_out_valid;
    assign s_job.c_mat     = r_c;
    assign s_job.overflow  = r_ovf;
    assign s_job.done_cnt  = r_done_cnt;

    assign o_arr_rst    = r_arr_rst;
    assign o_arr_enable = r_arr_en;

    assign o_arr_a_row1    = r_a_hold[row_ofs(0) +: WIDTH];
    assign o_arr_a_row2    = r_a_hold[row_ofs(1) +: WIDTH];
    assign o_arr_a_row3    = r_a_hold[row_ofs(2) +: WIDTH];
    assign o_arr_b_coloum1 = r_b_hold[row_ofs(0) +: WIDTH];
    assign o_arr_b_coloum2 = r_b_hold[row_ofs(1) +: WIDTH];
    assign o_arr_b_coloum3 = r_b_hold[row_ofs(2) +: WIDTH];

endmodule
